// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: req/ack bus handshake with timeout, byte lanes and load extension.
// Optional misaligned-access trap is enabled by defining MISALIGN_TRAP_EN.
module dmem_access_ctrl #(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  rw_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        misalign,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       rw_q;
    logic [1:0]       addr_lo_q;
    logic             access;
    logic             mis_req;

    function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] rt,
                                             input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (rt[1:0])
            2'b00:   return rt[2] ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   return rt[2] ? {16'b0, h} : {{16{h[15]}}, h};
            default: return w;
        endcase
    endfunction

    assign access = mem_read | mem_write;

`ifdef MISALIGN_TRAP_EN
    assign mis_req = ((rw_type[1:0] == 2'b01) && addr[0]) ||
                     (rw_type[1] && (addr[1:0] != 2'b00));
`else
    assign mis_req = 1'b0;
`endif

    // NOTE: stall must be combinational so the pipeline freezes in the same cycle the
    // request appears; it is gated by rst so a reset never leaves the pipeline frozen.
    assign stall = !rst && (((state == IDLE) && access) || (state == REQ));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rw_q      <= '0;
            addr_lo_q <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            misalign  <= 1'b0;
            rdata     <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
        end else begin
            // NOTE: pulse outputs default low here and are overridden by later non-blocking
            // assignments in the same block, giving single-cycle registered pulses.
            done     <= 1'b0;
            err      <= 1'b0;
            misalign <= 1'b0;
            case (state)
                IDLE: begin
                    if (access && mis_req) begin
                        state    <= ERR;
                        done     <= 1'b1;
                        err      <= 1'b1;
                        misalign <= 1'b1;
                        rdata    <= '0;
                    end else if (access) begin
                        state     <= REQ;
                        cnt       <= '0;
                        rw_q      <= rw_type;
                        addr_lo_q <= addr[1:0];
                        bus_req   <= 1'b1;
                        bus_we    <= !mem_read;
                        bus_addr  <= {addr[31:2], 2'b00};
                        bus_be    <= lane_be(rw_type[1:0], addr[1:0]);
                        bus_wdata <= lane_wdata(rw_type[1:0], wdata);
                    end
                end
                REQ: begin
                    // An ack arriving in the final timeout cycle still completes normally.
                    if (bus_ack) begin
                        state   <= DONE;
                        bus_req <= 1'b0;
                        done    <= 1'b1;
                        rdata   <= bus_we ? 32'b0 : load_ext(bus_rdata, rw_q, addr_lo_q);
                    end else if (cnt == CNT_LAST) begin
                        state   <= ERR;
                        bus_req <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        rdata   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: driver pushes expectations, bus responder and
// completion monitor pop and compare independently.
module tb_dmem_access_ctrl;
    localparam int TO = 16;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, mem_read, mem_write, bus_ack;
    logic [2:0]  rw_type;
    logic [31:0] addr, wdata, bus_rdata;
    logic        stall, done, err, misalign, bus_req, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        mis;
        int          stall_cyc;
    } exp_t;

    typedef struct {
        int          delay;
        logic [31:0] word;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } plan_t;

    exp_t  exp_q[$];
    plan_t plan_q[$];
    int    vectors = 0;
    int    miscompares = 0;

    dmem_access_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .rw_type(rw_type), .addr(addr), .wdata(wdata), .stall(stall), .done(done),
        .rdata(rdata), .err(err), .misalign(misalign), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Reference model: an access of n bytes touches the n-aligned byte offset within the word.
    task automatic issue(input bit rd, input bit wr, input logic [2:0] rt, input logic [31:0] a,
                         input logic [31:0] wd, input int delay, input logic [31:0] word,
                         input int gap);
        int          n, lo, off;
        bit          we, mis, got;
        logic [31:0] mask, val, rep;
        exp_t        e;
        plan_t       p;
        n    = (rt[1:0] == 2'b00) ? 1 : (rt[1:0] == 2'b01) ? 2 : 4;
        lo   = int'(a[1:0]);
        off  = (lo / n) * n;
        we   = wr && !rd;
        mis  = TRAP && ((lo % n) != 0);
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        val  = (word >> (8 * off)) & mask;
        if (!rt[2] && n < 4 && val[8 * n - 1]) val = val | ~mask;
        rep = '0;
        for (int i = 0; i < 4; i += n) rep = rep | ((wd & mask) << (8 * i));
        if (mis) begin
            e = '{32'h0, 1'b1, 1'b1, 1};
        end else begin
            p.delay = delay;
            p.word  = word;
            p.we    = we;
            p.addr  = a & 32'hFFFF_FFFC;
            p.be    = 4'(((1 << n) - 1) << off);
            p.wdata = rep;
            plan_q.push_back(p);
            if (delay >= TO) e = '{32'h0, 1'b1, 1'b0, 1 + TO};
            else             e = '{we ? 32'h0 : val, 1'b0, 1'b0, delay + 2};
        end
        exp_q.push_back(e);
        mem_read  = rd;
        mem_write = wr;
        rw_type   = rt;
        addr      = a;
        wdata     = wd;
        got = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            got = done;
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: got no done within 60 cycles, expected done");
            rst = 1'b1;
            @(negedge clk);
            exp_q.delete();
            plan_q.delete();
            rst = 1'b0;
        end
        repeat (gap) @(negedge clk);
    endtask

    // Bus responder: checks bus fields every REQ cycle and acks after the planned delay.
    initial begin
        plan_t p;
        bit    active;
        int    w;
        active    = 1'b0;
        w         = 0;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        forever begin
            @(negedge clk);
            #1;
            bus_ack   = 1'b0;
            bus_rdata = $urandom;
            if (rst || !bus_req) begin
                active = 1'b0;
            end else begin
                if (!active) begin
                    if (plan_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_bus_req: got bus_req=1 expected 0");
                        p = '{1000, 32'h0, bus_we, bus_addr, bus_be, bus_wdata};
                    end else begin
                        p = plan_q.pop_front();
                    end
                    active = 1'b1;
                    w      = 0;
                end
                check("bus_we", 32'(bus_we), 32'(p.we));
                check("bus_addr", bus_addr, p.addr);
                check("bus_be", 32'(bus_be), 32'(p.be));
                if (p.we) check("bus_wdata", bus_wdata, p.wdata);
                if (w == p.delay) begin
                    bus_ack   = 1'b1;
                    bus_rdata = p.word;
                end
                w++;
            end
        end
    end

    // Completion monitor: counts stall cycles per access and compares each done pulse.
    initial begin
        int   sc;
        exp_t e;
        sc = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                sc = 0;
            end else if (done) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: got done=1 expected 0");
                end else begin
                    e = exp_q.pop_front();
                    check("rdata", rdata, e.rdata);
                    check("err", 32'(err), 32'(e.err));
                    check("misalign", 32'(misalign), 32'(e.mis));
                    check("stall_cycles", 32'(sc), 32'(e.stall_cyc));
                end
                sc = 0;
            end else if (stall) begin
                sc++;
            end
        end
    end

    initial begin
        plan_t p;
        int    kind;
        int    dly;
        rst       = 1'b1;
        mem_read  = 1'b1;
        mem_write = 1'b0;
        rw_type   = 3'b010;
        addr      = 32'h100;
        wdata     = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_bus_req", 32'(bus_req), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_misalign", 32'(misalign), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_be", 32'(bus_be), 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        mem_read = 1'b0;
        rst      = 1'b0;
        @(negedge clk);

        issue(1, 0, 3'b010, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF, 1);
        issue(1, 0, 3'b000, 32'h0000_0103, 32'h0, 0, 32'h8012_3456, 0);
        issue(1, 0, 3'b100, 32'h0000_0103, 32'h0, 0, 32'h8012_3456, 0);
        issue(0, 1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 3, 32'h5555_AAAA, 1);
        issue(1, 0, 3'b010, 32'h0000_0300, 32'h0, TO, 32'h1111_2222, 0);
        issue(1, 0, 3'b010, 32'h0000_0304, 32'h0, TO - 1, 32'h3333_4444, 1);
        issue(1, 1, 3'b101, 32'h0000_0406, 32'hFFFF_FFFF, 1, 32'h9ABC_DEF0, 0);
        issue(1, 0, 3'b010, 32'h0000_0101, 32'h0, 0, 32'hCAFE_F00D, 1);
        issue(1, 0, 3'b001, 32'h0000_0503, 32'h0, 2, 32'hF00D_8765, 1);

        // Reset in the middle of an outstanding request; the transaction is abandoned.
        p = '{1000, 32'h0, 1'b0, 32'h0000_0600, 4'b1111, 32'h0};
        plan_q.push_back(p);
        mem_read = 1'b1;
        rw_type  = 3'b010;
        addr     = 32'h0000_0600;
        repeat (5) @(negedge clk);
        check("mid_req_bus_req", 32'(bus_req), 32'h1);
        rst = 1'b1;
        #1;
        check("rst_gates_stall", 32'(stall), 32'h0);
        @(negedge clk);
        check("post_rst_bus_req", 32'(bus_req), 32'h0);
        check("post_rst_done", 32'(done), 32'h0);
        mem_read = 1'b0;
        rst      = 1'b0;
        #1;
        check("post_rst_stall", 32'(stall), 32'h0);
        @(negedge clk);
        issue(1, 0, 3'b010, 32'h0000_0700, 32'h0, 0, 32'h0BAD_CAFE, 0);

        for (int t = 0; t < 250; t++) begin
            kind = $urandom_range(0, 2);
            dly  = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 2, TO + 1)
                                               : $urandom_range(0, 5);
            issue(kind != 1, kind != 0, 3'($urandom), $urandom, $urandom, dly, $urandom,
                  $urandom_range(0, 2));
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
